msg_arb2: RTL and testbench

- Two-requester round-robin arbiter that shares one outgoing message channel (e.g. the channel feeding a packetizer) between two independent 4-phase req/ack message sources.
- Captures the winning message into a holding register and acknowledges the source.
- Forwards the held message downstream under its own 4-phase handshake, then re-arbitrates.
- Sits between message producers and a single pakout-style consumer.

---
 rtl/msg_arb2_pkg.sv | 23 ++
 rtl/msg_arb2_hs_sync.sv | 29 ++
 rtl/msg_arb2.sv | 112 +++++++++++
 tb/tb_msg_arb2.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_arb2_pkg.sv
// Shared definitions for the two-input round-robin message arbiter:
// handshake levels, FSM encoding and the default message width.
package msg_arb2_pkg;

    localparam int ADDR_SZ = 12;
    localparam int DATA_SZ = 16;
    localparam int RED_SZ  = 4;
    localparam int MSG_SZ  = ADDR_SZ + DATA_SZ + RED_SZ;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // A lone request wins outright; a tie goes to whoever was not served last.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
        return (req0 && req1) ? ~last : req1;
    endfunction

endpackage

// File: rtl/msg_arb2_hs_sync.sv
// Multi-flop synchronizer for one asynchronous handshake line, cleared
// asynchronously so no stale request or ack survives a reset.
module msg_arb2_hs_sync
    import msg_arb2_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            chain <= {STAGES{OFF}};
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/msg_arb2.sv
// Round-robin arbiter sharing one 4-phase outgoing message channel between
// two 4-phase message sources; the winner's message is held until delivered.
module msg_arb2
    import msg_arb2_pkg::*;
#(
    parameter int MSZ   = MSG_SZ,
    parameter int SYNC  = 2,
    parameter bit FIRST = 1'b0
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [MSZ-1:0] rcv0_data,
    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [MSZ-1:0] rcv1_data,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [MSZ-1:0] snd0_data,
    output logic           grant,
    output logic           busy
);

    arb_state_t state;
    logic       s_req0;
    logic       s_req1;
    logic       s_ack;
    logic       out_done;
    logic       next_grant;
    logic       cur_ack;

    msg_arb2_hs_sync #(.STAGES(SYNC)) u_sync_req0 (
        .i_clk (i_clk),
        .reset (reset),
        .d     (rcv0_req),
        .q     (s_req0)
    );

    msg_arb2_hs_sync #(.STAGES(SYNC)) u_sync_req1 (
        .i_clk (i_clk),
        .reset (reset),
        .d     (rcv1_req),
        .q     (s_req1)
    );

    msg_arb2_hs_sync #(.STAGES(SYNC)) u_sync_ack (
        .i_clk (i_clk),
        .reset (reset),
        .d     (snd0_ack),
        .q     (s_ack)
    );

    assign next_grant = pick_winner(s_req0, s_req1, grant);
    assign cur_ack    = grant ? rcv1_ack : rcv0_ack;
    assign busy       = (state != IDLE);

    // Input and output handshakes retire independently inside XFER; the
    // channel is only re-arbitrated once both have fully returned to zero.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ready     <= OFF;
            rcv0_ack  <= OFF;
            rcv1_ack  <= OFF;
            snd0_req  <= OFF;
            snd0_data <= '0;
            grant     <= ~FIRST;
            out_done  <= OFF;
        end else begin
            ready <= ON;
            case (state)
                IDLE: begin
                    if (s_req0 || s_req1) begin
                        if (next_grant) begin
                            snd0_data <= rcv1_data;
                            rcv1_ack  <= ON;
                        end else begin
                            snd0_data <= rcv0_data;
                            rcv0_ack  <= ON;
                        end
                        snd0_req <= ON;
                        grant    <= next_grant;
                        out_done <= OFF;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (!s_req0) begin
                        rcv0_ack <= OFF;
                    end
                    if (!s_req1) begin
                        rcv1_ack <= OFF;
                    end
                    if (s_ack) begin
                        snd0_req <= OFF;
                        out_done <= ON;
                    end
                    if (!cur_ack && out_done && !s_ack) begin
                        out_done <= OFF;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_arb2.sv
// Directed scoreboard bench for msg_arb2 with auto-responding 4-phase
// source and consumer models.
module tb_msg_arb2;

    localparam int MSZ   = 32;
    localparam int SYNC  = 2;
    localparam bit FIRST = 1'b0;

    logic           i_clk = 1'b0;
    logic           reset;
    logic           ready;
    logic           rcv0_req;
    logic           rcv0_ack;
    logic [MSZ-1:0] rcv0_data;
    logic           rcv1_req;
    logic           rcv1_ack;
    logic [MSZ-1:0] rcv1_data;
    logic           snd0_req;
    logic           snd0_ack;
    logic [MSZ-1:0] snd0_data;
    logic           grant;
    logic           busy;

    int total = 0;
    int bad   = 0;

    logic [MSZ-1:0] src0_q[$];
    logic [MSZ-1:0] src1_q[$];
    logic [MSZ-1:0] exp0_q[$];
    logic [MSZ-1:0] exp1_q[$];
    logic           exp_grant_q[$];
    int             rise_q[$];

    bit flush      = 1'b0;
    int cons_delay = 1;
    int wait_cnt   = 0;

    int             cyc         = 0;
    int             req0_cyc    = 0;
    int             lat0        = -1;
    int             ack_cnt0    = 0;
    int             ack_cnt1    = 0;
    int             hi_cnt      = 0;
    int             last_hi     = 0;
    int             fall_cnt    = 0;
    bit             stable      = 1'b1;
    bit             last_stable = 1'b1;
    logic [MSZ-1:0] hold_data   = '0;
    logic           prev_req0   = 1'b0;
    logic           prev_ack0   = 1'b0;
    logic           prev_ack1   = 1'b0;
    logic           prev_snd    = 1'b0;

    msg_arb2 #(.MSZ(MSZ), .SYNC(SYNC), .FIRST(FIRST)) dut (
        .i_clk     (i_clk),
        .reset     (reset),
        .ready     (ready),
        .rcv0_req  (rcv0_req),
        .rcv0_ack  (rcv0_ack),
        .rcv0_data (rcv0_data),
        .rcv1_req  (rcv1_req),
        .rcv1_ack  (rcv1_ack),
        .rcv1_data (rcv1_data),
        .snd0_req  (snd0_req),
        .snd0_ack  (snd0_ack),
        .snd0_data (snd0_data),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit src, input logic [MSZ-1:0] data);
        if (src) begin
            src1_q.push_back(data);
            exp1_q.push_back(data);
        end else begin
            src0_q.push_back(data);
            exp0_q.push_back(data);
        end
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int quiet = 0;
        bit done  = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge i_clk); #2;
            if (src0_q.size() == 0 && src1_q.size() == 0 && exp_grant_q.size() == 0 &&
                exp0_q.size() == 0 && exp1_q.size() == 0 &&
                !rcv0_req && !rcv1_req && !rcv0_ack && !rcv1_ack &&
                !snd0_req && !snd0_ack && !busy)
                quiet++;
            else
                quiet = 0;
            if (quiet >= 2*SYNC + 2) done = 1'b1;
        end
        checkOutput({tag, "_drain"}, 64'(done), 64'd1);
    endtask

    // Requester models: raise on queued data, drop on ack, flush on reset.
    initial begin
        rcv0_req  = 1'b0;
        rcv0_data = '0;
        forever begin
            @(negedge i_clk);
            if (flush) begin
                rcv0_req = 1'b0;
                src0_q.delete();
            end else if (rcv0_req && rcv0_ack) begin
                rcv0_req = 1'b0;
            end else if (!rcv0_req && !rcv0_ack && src0_q.size() > 0 && reset) begin
                rcv0_data = src0_q.pop_front();
                rcv0_req  = 1'b1;
            end
        end
    end

    initial begin
        rcv1_req  = 1'b0;
        rcv1_data = '0;
        forever begin
            @(negedge i_clk);
            if (flush) begin
                rcv1_req = 1'b0;
                src1_q.delete();
            end else if (rcv1_req && rcv1_ack) begin
                rcv1_req = 1'b0;
            end else if (!rcv1_req && !rcv1_ack && src1_q.size() > 0 && reset) begin
                rcv1_data = src1_q.pop_front();
                rcv1_req  = 1'b1;
            end
        end
    end

    // Consumer acks on the cons_delay-th falling edge after snd0_req rises.
    initial begin
        snd0_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!snd0_req) begin
                snd0_ack = 1'b0;
                wait_cnt = 0;
            end else if (!snd0_ack) begin
                wait_cnt++;
                if (wait_cnt >= cons_delay) snd0_ack = 1'b1;
            end
        end
    end

    initial begin
        logic g;
        bit   has;
        forever begin
            @(posedge i_clk); #1;
            cyc++;
            if (rcv0_req && !prev_req0) req0_cyc = cyc;
            if (rcv0_ack && !prev_ack0) begin
                ack_cnt0++;
                lat0 = cyc - req0_cyc + 1;
            end
            if (rcv1_ack && !prev_ack1) ack_cnt1++;
            if (snd0_req && !prev_snd) begin
                rise_q.push_back(cyc);
                hold_data = snd0_data;
                hi_cnt    = 1;
                stable    = 1'b1;
                checkOutput("sb_grant_pending", 64'(exp_grant_q.size() > 0), 64'd1);
                if (exp_grant_q.size() > 0) begin
                    g = exp_grant_q.pop_front();
                    checkOutput("grant", 64'(grant), 64'(g));
                    has = g ? (exp1_q.size() > 0) : (exp0_q.size() > 0);
                    checkOutput("sb_data_pending", 64'(has), 64'd1);
                    if (has) checkOutput("snd0_data", 64'(snd0_data), 64'(g ? exp1_q.pop_front() : exp0_q.pop_front()));
                end
            end else if (snd0_req) begin
                hi_cnt++;
                if (snd0_data !== hold_data) stable = 1'b0;
            end
            if (!snd0_req && prev_snd) begin
                last_hi     = hi_cnt;
                last_stable = stable;
                fall_cnt++;
            end
            prev_req0 = rcv0_req;
            prev_ack0 = rcv0_ack;
            prev_ack1 = rcv1_ack;
            prev_snd  = snd0_req;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  a0, a1, f0, n;
        bit  seen, viol;
        reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        checkOutput("rst_ready",     64'(ready),     64'd0);
        checkOutput("rst_rcv0_ack",  64'(rcv0_ack),  64'd0);
        checkOutput("rst_rcv1_ack",  64'(rcv1_ack),  64'd0);
        checkOutput("rst_snd0_req",  64'(snd0_req),  64'd0);
        checkOutput("rst_snd0_data", 64'(snd0_data), 64'd0);
        checkOutput("rst_grant",     64'(grant),     64'(!FIRST));
        checkOutput("rst_busy",      64'(busy),      64'd0);
        reset = 1'b1;
        #1;
        checkOutput("ready_pre_edge", 64'(ready), 64'd0);
        @(posedge i_clk); #2;
        checkOutput("ready_post_edge", 64'(ready), 64'd1);

        // Simultaneous requests: FIRST wins the tie, rcv1 waits out the whole transfer.
        applyStimulus(1'b0, 32'h1);
        applyStimulus(1'b1, 32'h2);
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b1);
        seen = 1'b0;
        viol = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge i_clk); #2;
            if (busy) seen = 1'b1;
            if (rcv1_ack) viol = 1'b1;
        end
        n = 0;
        while (busy && n < 40) begin
            if (rcv1_ack) viol = 1'b1;
            @(posedge i_clk); #2;
            n++;
        end
        if (rcv1_ack) viol = 1'b1;
        checkOutput("sim_busy_seen",   64'(seen), 64'd1);
        checkOutput("sim_first_idle",  64'(busy), 64'd0);
        checkOutput("sim_rcv1_waited", 64'(viol), 64'd0);
        waitDrain("sim", 200);
        checkOutput("sim_grant_end", 64'(grant), 64'd1);

        // Fairness: both always pending, grants must alternate 0,1,0,1...
        a0 = ack_cnt0;
        a1 = ack_cnt1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, MSZ'(32'h100 + k));
            applyStimulus(1'b1, MSZ'(32'h200 + k));
            exp_grant_q.push_back(1'b0);
            exp_grant_q.push_back(1'b1);
        end
        waitDrain("rr", 400);
        checkOutput("rr_acks0", 64'(ack_cnt0 - a0), 64'd4);
        checkOutput("rr_acks1", 64'(ack_cnt1 - a1), 64'd4);

        // Single request with a consumer acking after 3 cycles.
        cons_delay = 3;
        lat0 = -1;
        applyStimulus(1'b0, 32'hA5A5_0001);
        exp_grant_q.push_back(1'b0);
        waitDrain("single", 200);
        checkOutput("single_ack_latency", 64'(lat0), 64'(SYNC + 1));
        checkOutput("single_grant", 64'(grant), 64'd0);
        checkOutput("single_busy",  64'(busy),  64'd0);

        // Slow consumer: input side retires early, the queued request waits for IDLE.
        cons_delay = 20;
        a0 = ack_cnt0;
        f0 = fall_cnt;
        applyStimulus(1'b0, 32'hC0DE_0001);
        applyStimulus(1'b0, 32'hC0DE_0002);
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b0);
        n = 0;
        while (fall_cnt == f0 && n < 100) begin
            @(posedge i_clk); #2;
            n++;
        end
        checkOutput("slow_req_fell",    64'(fall_cnt - f0), 64'd1);
        checkOutput("slow_req_hold",    64'(last_hi),       64'(20 + SYNC));
        checkOutput("slow_data_stable", 64'(last_stable),   64'd1);
        checkOutput("slow_in_early",    64'(rcv0_ack),      64'd0);
        viol = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (rcv0_ack) viol = 1'b1;
            @(posedge i_clk); #2;
            n++;
        end
        checkOutput("slow_no_early_ack", 64'(viol),            64'd0);
        checkOutput("slow_acks_mid",     64'(ack_cnt0 - a0),   64'd1);
        waitDrain("slow", 200);
        checkOutput("slow_acks_total",   64'(ack_cnt0 - a0),   64'd2);

        // Reset while the held message is being offered downstream.
        cons_delay = 5;
        applyStimulus(1'b0, 32'hDEAD_0001);
        exp_grant_q.push_back(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge i_clk); #2;
            if (snd0_req) seen = 1'b1;
        end
        checkOutput("mrst_req_seen", 64'(seen), 64'd1);
        reset = 1'b0;
        flush = 1'b1;
        #1;
        checkOutput("mrst_snd0_req",  64'(snd0_req),  64'd0);
        checkOutput("mrst_rcv0_ack",  64'(rcv0_ack),  64'd0);
        checkOutput("mrst_rcv1_ack",  64'(rcv1_ack),  64'd0);
        checkOutput("mrst_ready",     64'(ready),     64'd0);
        checkOutput("mrst_busy",      64'(busy),      64'd0);
        checkOutput("mrst_snd0_data", 64'(snd0_data), 64'd0);
        checkOutput("mrst_grant",     64'(grant),     64'(!FIRST));
        repeat (3) @(posedge i_clk);
        #2;
        flush = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("mrst_ready_pre", 64'(ready), 64'd0);
        @(posedge i_clk); #2;
        checkOutput("mrst_ready_post", 64'(ready), 64'd1);
        cons_delay = 1;
        applyStimulus(1'b0, 32'h600D_0001);
        exp_grant_q.push_back(1'b0);
        waitDrain("mrst", 200);
        checkOutput("mrst_grant_after", 64'(grant), 64'd0);

        // Back-to-back on rcv1 with instant peers: grant-to-grant spacing.
        rise_q.delete();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, MSZ'(32'hB0B0_0000 + k));
            exp_grant_q.push_back(1'b1);
        end
        waitDrain("b2b", 300);
        checkOutput("b2b_count", 64'(rise_q.size()), 64'd3);
        if (rise_q.size() == 3) begin
            checkOutput("b2b_gap1", 64'(rise_q[1] - rise_q[0]), 64'(2*SYNC + 3));
            checkOutput("b2b_gap2", 64'(rise_q[2] - rise_q[1]), 64'(2*SYNC + 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
